// File: rtl/sound_pkg.sv
// Shared constants for the audio stage: register map, noise LFSR seed/taps
// and the control-register enable bit position.
package sound_pkg;

    localparam logic [2:0] REG_CH0_LO  = 3'd0;
    localparam logic [2:0] REG_CH0_HI  = 3'd1;
    localparam logic [2:0] REG_CH0_CTL = 3'd2;
    localparam logic [2:0] REG_CH1_LO  = 3'd3;
    localparam logic [2:0] REG_CH1_HI  = 3'd4;
    localparam logic [2:0] REG_CH1_CTL = 3'd5;
    localparam logic [2:0] REG_NZ_CTL  = 3'd6;
    localparam logic [2:0] REG_NZ_PER  = 3'd7;

    localparam logic [14:0] LFSR_SEED  = 15'h0001;
    localparam int          LFSR_TAP_A = 14;
    localparam int          LFSR_TAP_B = 13;

    localparam int ENABLE_BIT = 7;

    function automatic logic [14:0] lfsr_next(input logic [14:0] s);
        return {s[13:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/square_channel.sv
// One square-wave tone channel: half-period of `period` ticks, amplitude is
// `volume` while the phase is high.
module square_channel #(
    parameter int PERIOD_W = 12
) (
    input  logic                clk_12_5875,
    input  logic                rst,
    input  logic                tick,
    input  logic [PERIOD_W-1:0] period,
    input  logic                enable,
    input  logic [3:0]          volume,
    output logic [3:0]          amplitude
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    // Idle channels are parked every cycle so a restart always begins at cnt=1, phase low.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable || period == '0) begin
            cnt_d   = PERIOD_W'(1);
            phase_d = 1'b0;
        end else if (tick) begin
            if (cnt_q >= period) begin
                cnt_d   = PERIOD_W'(1);
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            cnt_q   <= PERIOD_W'(1);
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign amplitude = phase_q ? volume : 4'd0;

endmodule

// File: rtl/sound_generator.sv
// Bus-mapped audio stage: two square channels plus an LFSR noise channel,
// mixed to a 6-bit sample and emitted as a 64-step PWM stream.
module sound_generator
    import sound_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int PERIOD_W = 12
) (
    input  logic       clk_12_5875,
    input  logic       rst,
    input  logic [2:0] reg_address,
    input  logic [7:0] data_in,
    input  logic       write_strobe,
    output logic [5:0] sample_out,
    output logic       pwm_out
);

    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0]     presc_q, presc_d;
    logic                tick;
    logic [PERIOD_W-1:0] ch0_per_q, ch0_per_d, ch1_per_q, ch1_per_d;
    logic                ch0_en_q, ch0_en_d, ch1_en_q, ch1_en_d, nz_en_q, nz_en_d;
    logic [3:0]          ch0_vol_q, ch0_vol_d, ch1_vol_q, ch1_vol_d, nz_vol_q, nz_vol_d;
    logic [3:0]          nz_per_q, nz_per_d, div_q, div_d;
    logic [14:0]         lfsr_q, lfsr_d;
    logic [3:0]          ch0_amp, ch1_amp, nz_amp;
    logic [5:0]          sample_q, sample_d, pc_q;
    logic                pwm_q, pwm_d;

    assign tick    = (presc_q == PS_W'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + PS_W'(1);

    always_comb begin
        ch0_per_d = ch0_per_q;  ch0_en_d = ch0_en_q;  ch0_vol_d = ch0_vol_q;
        ch1_per_d = ch1_per_q;  ch1_en_d = ch1_en_q;  ch1_vol_d = ch1_vol_q;
        nz_en_d   = nz_en_q;    nz_vol_d = nz_vol_q;  nz_per_d  = nz_per_q;
        if (write_strobe) begin
            unique case (reg_address)
                REG_CH0_LO:  ch0_per_d[7:0]          = data_in;
                REG_CH0_HI:  ch0_per_d[PERIOD_W-1:8] = data_in[PERIOD_W-9:0];
                REG_CH0_CTL: begin ch0_en_d = data_in[ENABLE_BIT]; ch0_vol_d = data_in[3:0]; end
                REG_CH1_LO:  ch1_per_d[7:0]          = data_in;
                REG_CH1_HI:  ch1_per_d[PERIOD_W-1:8] = data_in[PERIOD_W-9:0];
                REG_CH1_CTL: begin ch1_en_d = data_in[ENABLE_BIT]; ch1_vol_d = data_in[3:0]; end
                REG_NZ_CTL:  begin nz_en_d  = data_in[ENABLE_BIT]; nz_vol_d  = data_in[3:0]; end
                REG_NZ_PER:  nz_per_d = data_in[3:0];
                default: ;
            endcase
        end
    end

    // Channels see the incoming enable so a disable written on a tick cycle wins,
    // while period writes only take effect from the following tick.
    square_channel #(.PERIOD_W(PERIOD_W)) u_ch0 (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .tick        (tick),
        .period      (ch0_per_q),
        .enable      (ch0_en_d),
        .volume      (ch0_vol_q),
        .amplitude   (ch0_amp)
    );

    square_channel #(.PERIOD_W(PERIOD_W)) u_ch1 (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .tick        (tick),
        .period      (ch1_per_q),
        .enable      (ch1_en_d),
        .volume      (ch1_vol_q),
        .amplitude   (ch1_amp)
    );

    always_comb begin
        lfsr_d = lfsr_q;
        div_d  = div_q;
        if (nz_en_q && tick) begin
            if (div_q >= nz_per_q) begin
                div_d  = 4'd0;
                lfsr_d = lfsr_next(lfsr_q);
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    assign nz_amp   = (nz_en_q && lfsr_q[0]) ? nz_vol_q : 4'd0;
    assign sample_d = {2'b00, ch0_amp} + {2'b00, ch1_amp} + {2'b00, nz_amp};
    assign pwm_d    = (pc_q < sample_q);

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            presc_q   <= '0;
            ch0_per_q <= '0;  ch0_en_q <= 1'b0;  ch0_vol_q <= 4'd0;
            ch1_per_q <= '0;  ch1_en_q <= 1'b0;  ch1_vol_q <= 4'd0;
            nz_en_q   <= 1'b0; nz_vol_q <= 4'd0; nz_per_q  <= 4'd0;
            div_q     <= 4'd0;
            lfsr_q    <= LFSR_SEED;
            sample_q  <= 6'd0;
            pc_q      <= 6'd0;
            pwm_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            ch0_per_q <= ch0_per_d; ch0_en_q <= ch0_en_d; ch0_vol_q <= ch0_vol_d;
            ch1_per_q <= ch1_per_d; ch1_en_q <= ch1_en_d; ch1_vol_q <= ch1_vol_d;
            nz_en_q   <= nz_en_d;   nz_vol_q <= nz_vol_d; nz_per_q  <= nz_per_d;
            div_q     <= div_d;
            lfsr_q    <= lfsr_d;
            sample_q  <= sample_d;
            pc_q      <= pc_q + 6'd1;
            pwm_q     <= pwm_d;
        end
    end

    assign sample_out = sample_q;
    assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_sound_generator.sv
// Directed bench for sound_generator: tone timing, period change, noise
// sequence, full-scale mix, tick-cycle disable and mid-tone reset.
module tb_sound_generator;
    import sound_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] reg_address;
    logic [7:0] data_in;
    logic       write_strobe;
    logic [5:0] sample_out;
    logic       pwm_out;

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_presc;
    logic [15:0] nz_bits;

    sound_generator #(.PRESCALE(16), .PERIOD_W(12)) dut (
        .clk_12_5875  (clk),
        .rst          (rst),
        .reg_address  (reg_address),
        .data_in      (data_in),
        .write_strobe (write_strobe),
        .sample_out   (sample_out),
        .pwm_out      (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent prescaler phase model: tick happens while m_presc == 15.
    always @(posedge clk) begin
        if (rst) m_presc <= 4'd0;
        else     m_presc <= m_presc + 4'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_address  = a;
        data_in      = d;
        write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic wait_sample(input string tag, input logic [5:0] val, input int budget);
        int n = 0;
        while (sample_out !== val && n < budget) begin
            step();
            n++;
        end
        check(tag, sample_out, val);
    endtask

    task automatic hold(input string tag, input logic [5:0] val, input int len);
        for (int i = 0; i < len; i++) begin
            check(tag, sample_out, val);
            step();
        end
    endtask

    task automatic pwm_duty(input string tag, input int exp_high);
        int c = 0;
        for (int i = 0; i < 64; i++) begin
            if (pwm_out === 1'b1) c++;
            step();
        end
        check(tag, c, exp_high);
    endtask

    task automatic wait_presc(input logic [3:0] v);
        int n = 0;
        while (m_presc !== v && n < 32) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        reg_address  = 3'd0;
        data_in      = 8'd0;
        write_strobe = 1'b0;
        nz_bits      = 16'hC001;
        repeat (3) step();
        check("rst_sample", sample_out, 6'd0);
        check("rst_pwm", pwm_out, 1'b0);
        check("rst_lfsr", dut.lfsr_q, 15'h0001);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10000; i++) begin
            check("idle_sample", sample_out, 6'd0);
            check("idle_pwm", pwm_out, 1'b0);
            step();
        end

        // 2: P=1, volume 15 -> 16 clocks high, 16 low
        wr(REG_CH0_LO, 8'd1);
        wr(REG_CH0_HI, 8'd0);
        wr(REG_CH0_CTL, 8'h8F);
        wait_sample("p1_rise", 6'd15, 64);
        hold("p1_high", 6'd15, 16);
        hold("p1_low", 6'd0, 16);
        hold("p1_high2", 6'd15, 16);
        wr(REG_CH0_CTL, 8'h00);
        step();
        check("ch0_disable", sample_out, 6'd0);

        // 3: P=100, then shrink to 3 mid-period
        wr(REG_CH0_LO, 8'd100);
        wr(REG_CH0_CTL, 8'h8F);
        wait_sample("p100_rise", 6'd15, 1700);
        repeat (2) step();
        pwm_duty("pwm_15", 15);
        repeat (718) step();
        wr(REG_CH0_LO, 8'd3);
        wait_sample("p3_early_toggle", 6'd0, 40);
        hold("p3_low", 6'd0, 48);
        hold("p3_high", 6'd15, 48);
        check("p3_toggle", sample_out, 6'd0);
        wr(REG_CH0_CTL, 8'h00);
        step();
        check("ch0_off", sample_out, 6'd0);

        // 4: noise every tick, volume 10
        wr(REG_NZ_PER, 8'd0);
        wait_presc(4'd2);
        wr(REG_NZ_CTL, 8'h8A);
        wait_presc(4'd8);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("nz_bit%0d", i), sample_out, nz_bits[i] ? 6'd10 : 6'd0);
            repeat (16) step();
        end
        wr(REG_NZ_CTL, 8'h0A);
        step();
        check("nz_disable", sample_out, 6'd0);

        // 5: full-scale mix, then disable CH1 on a tick cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr(REG_CH0_LO, 8'd100);
        wr(REG_CH0_HI, 8'd0);
        wr(REG_CH0_CTL, 8'h8F);
        wr(REG_CH1_LO, 8'd100);
        wr(REG_CH1_HI, 8'd0);
        wr(REG_CH1_CTL, 8'h8F);
        wait_sample("dual_rise", 6'd30, 1800);
        wr(REG_NZ_PER, 8'd15);
        wr(REG_NZ_CTL, 8'h8F);
        step();
        check("mix_45", sample_out, 6'd45);
        repeat (2) step();
        pwm_duty("pwm_45", 45);
        wait_presc(4'd15);
        wr(REG_CH1_CTL, 8'h00);
        check("tick_dis_c1", sample_out, 6'd45);
        step();
        check("tick_dis_c2", sample_out, 6'd30);

        // 6: one-cycle reset mid-tone
        rst = 1'b1;
        step();
        check("mid_rst_sample", sample_out, 6'd0);
        check("mid_rst_pwm", pwm_out, 1'b0);
        check("mid_rst_lfsr", dut.lfsr_q, 15'h0001);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            check("post_rst_sample", sample_out, 6'd0);
            check("post_rst_pwm", pwm_out, 1'b0);
            step();
        end
        wr(REG_CH0_CTL, 8'h8F);
        hold("p0_silent", 6'd0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_generator.md
Name: sound_generator

Overview:
- Bus-mapped audio stage driven by the address decode / data bus of the console top level. It is the consumer of a new SELECT_audio decode, carrying 8 write-only registers.
- Generates two square-wave channels and one LFSR noise channel, and mixes them into a 6-bit sample.
- Emits a 1-bit PWM stream for an external RC filter to the speaker.
- All logic runs in the 12.5875 MHz pixel-clock domain; the top level presents CPU writes as one-cycle strobes already synchronized to that domain.

Parameters:
- PRESCALE, 16, clk_12_5875 cycles per audio tick (must be >=2); tick rate about 786.7 kHz at default.
- PERIOD_W, 12, square-channel period register width.

Ports:
- clk_12_5875  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- reg_address  input  3  register select, equal to cpu_address[2:0] within the audio window.
- data_in  input  8  write data.
- write_strobe  input  1  one-cycle write pulse: SELECT_audio && write_enable, synchronized.
- sample_out  output  6  registered mixed sample, 0..45.
- pwm_out  output  1  registered PWM of sample_out.

Behaviour:
- Register map (unused bits ignored on write, register reads not supported):
  - 0 CH0_LO: period[7:0]
  - 1 CH0_HI: period[11:8] in data[3:0]
  - 2 CH0_CTL: data[7] = enable, data[3:0] = volume
  - 3, 4, 5: CH1_LO, CH1_HI, CH1_CTL, same layout as channel 0
  - 6 NZ_CTL: data[7] = enable, data[3:0] = volume
  - 7 NZ_PER: data[3:0] = N
- Register write latency: the register updates on the clock edge where write_strobe=1.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for the single cycle where the count equals PRESCALE-1.
- Square channel, per channel:
  - 12-bit counter cnt and a phase bit.
  - On tick with enable=1 and P!=0: if cnt>=P, set cnt<=1 and toggle phase; else cnt<=cnt+1.
  - Result: half-period is exactly P ticks, and f = clk/(2*PRESCALE*P).
  - A period change takes effect at the next compare; there is no glitch reload. If cnt already exceeds the new P, the channel toggles on the next tick.
  - If P==0 or enable==0: phase<=0 and cnt<=1, applied every cycle, not just on tick.
  - Amplitude = phase ? volume : 0.
- Noise channel:
  - 15-bit LFSR seeded 15'h0001; feedback = lfsr[14]^lfsr[13], shifted in at bit 0. Full period is 32767.
  - A 4-bit divider shifts the LFSR every N+1 ticks.
  - enable==0: LFSR and divider hold their values; amplitude = 0.
  - Amplitude = lfsr[0] ? volume : 0.
- Mixer:
  - mix = ch0 + ch1 + nz as zero-extended 6-bit; max 45, cannot overflow.
  - sample_out <= mix, one cycle after the amplitude changes.
- PWM:
  - 6-bit free-running counter pc, 0..63, wrapping, advancing every clock.
  - pwm_out <= (pc < sample_out).
  - sample_out=0 gives constant 0; maximum duty is 45/64.
- Simultaneous events:
  - A write to CTL clearing enable on a tick cycle: the disable wins, phase=0 on the next cycle.
  - A write to LO/HI on a tick cycle: the compare uses the old P, the new P applies from the next tick.
- Reset (any cycle, mid-operation included):
  - All registers 0, cnt=1, phase=0, lfsr=15'h0001, prescaler=0, pc=0.
  - sample_out=0 and pwm_out=0 on the cycle after rst is sampled high.

Decomposition:
- Package sound_pkg holds:
  - register address constants REG_CH0_LO..REG_NZ_PER;
  - LFSR_SEED = 15'h0001;
  - the LFSR tap positions;
  - the ENABLE_BIT index (7).
- One sub-module, square_channel, with ports: clk_12_5875, rst, tick, period[11:0], enable, volume[3:0], amplitude[3:0]. It is instantiated twice.
- The noise channel, mixer and PWM stay inline.

Test Plan:
1. Reset with no writes -> sample_out=0 and pwm_out=0 for 10000 cycles.
2. PRESCALE=16; write CH0_LO=1, CH0_HI=0, CH0_CTL=8'h8F -> ch0 phase toggles every 16 clocks. sample_out alternates 0/15 with a 32-clock period; pwm_out high 15 of every 64 clocks while the sample is 15.
3. CH0 with P=100 running; write P=3 mid-period while cnt=50 -> toggle on the next tick, then a half-period of 3 ticks thereafter.
4. NZ_CTL=8'h8A, NZ_PER=0 -> LFSR shifts every tick. The first 16 lfsr[0] values match a reference model from seed 0001; lfsr returns to 15'h0001 after 32767 shifts.
5. All three channels at volume 15, with phases and lfsr[0] high -> sample_out=45 and pwm duty exactly 45/64. Then write CH1_CTL=0 on a tick cycle -> sample_out drops to 30 two cycles later.
6. Assert rst for 1 cycle mid-tone -> next cycle all outputs 0 and lfsr=0001. After release, registers read back behaviour as disabled until rewritten.
